// File: rtl/fft_pkg.sv
// fft_pkg: constants, complex sample type and bit-reverse helper shared by the FFT pipeline
package fft_pkg;
  localparam int DEF_DW = 14;
  localparam int DEF_LOG2N = 4;
  typedef struct packed {
    logic signed [DEF_DW-1:0] re;
    logic signed [DEF_DW-1:0] im;
  } cplx_t;
  // Reverse the low w bits of x; bits above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
    logic [31:0] r;
    r = {<<{x}};
    return r >> (32 - w);
  endfunction
endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// fft_bitrev_reorder_if: natural-order output stream of the bit-reverse reorder buffer
// master drives valid/re/im/last (and idx when FFT_REORDER_IDX_EN is defined); slave drives ready.
interface fft_bitrev_reorder_if
  import fft_pkg::*;
#(
  parameter int DW = DEF_DW
`ifdef FFT_REORDER_IDX_EN
  , parameter int LOG2N = DEF_LOG2N
`endif
);
  logic valid;
  logic ready;
  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic last;
`ifdef FFT_REORDER_IDX_EN
  logic [LOG2N-1:0] idx;
  modport master (output valid, re, im, last, idx, input ready);
  modport slave (input valid, re, im, last, idx, output ready);
`else
  modport master (output valid, re, im, last, input ready);
  modport slave (input valid, re, im, last, output ready);
`endif
endinterface

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two banks of 2**LOG2N complex words, sync write, async read
// Ports: clk; we/wr_bank/wr_addr/wr_data write port; rd_bank/rd_addr -> rd_data read port.
module fft_pingpong_ram #(
  parameter int DW = 14,
  parameter int LOG2N = 4
) (
  input  logic clk,
  input  logic we,
  input  logic wr_bank,
  input  logic [LOG2N-1:0] wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic rd_bank,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [2*DW-1:0] rd_data
);
  logic [2*DW-1:0] mem [2**(LOG2N+1)];
  always_ff @(posedge clk) if (we) mem[{wr_bank, wr_addr}] <= wr_data;
  assign rd_data = mem[{rd_bank, rd_addr}];
endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT frames into a natural-order stream
// Ports: clk, rst (sync, active-high); in_valid/in_re/in_im unstallable bit-reversed input;
// out (master) natural-order valid/ready stream with last; overflow sticky drop flag.
// Optional FFT_REORDER_IDX_EN adds out.idx, the natural index of the current word.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  fft_bitrev_reorder_if.master out,
  output logic overflow
);
  logic [1:0] full_q, full_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, wr_addr;
  logic valid_q, valid_d, last_q, last_d, ovf_q, ovf_d;
  logic signed [DW-1:0] re_q, re_d, im_q, im_d;
  logic wr_ok, wr_end, adv, rd_ok, rd_end;
  logic [2*DW-1:0] rd_data;
`ifdef FFT_REORDER_IDX_EN
  logic [LOG2N-1:0] idx_q, idx_d;
`endif
  fft_pingpong_ram #(.DW(DW), .LOG2N(LOG2N)) u_ram (
    .clk(clk),
    .we(wr_ok),
    .wr_bank(wr_bank_q),
    .wr_addr(wr_addr),
    .wr_data({in_re, in_im}),
    .rd_bank(rd_bank_q),
    .rd_addr(rd_cnt_q),
    .rd_data(rd_data)
  );
  // A bank is only written while empty and only read while full, so the
  // full-set and full-clear below never hit the same bank in one cycle.
  always_comb begin
    wr_addr = LOG2N'(bitrev(32'(wr_cnt_q), LOG2N));
    wr_ok = in_valid && !full_q[wr_bank_q];
    wr_end = wr_ok && &wr_cnt_q;
    adv = !valid_q || out.ready;
    rd_ok = adv && full_q[rd_bank_q];
    rd_end = rd_ok && &rd_cnt_q;
    full_d = (full_q | (wr_end ? 2'b01 << wr_bank_q : 2'b00)) & ~(rd_end ? 2'b01 << rd_bank_q : 2'b00);
    wr_cnt_d = wr_ok ? wr_cnt_q + 1'b1 : wr_cnt_q;
    wr_bank_d = wr_bank_q ^ wr_end;
    rd_cnt_d = rd_ok ? rd_cnt_q + 1'b1 : rd_cnt_q;
    rd_bank_d = rd_bank_q ^ rd_end;
    valid_d = adv ? rd_ok : valid_q;
    last_d = adv ? rd_end : last_q;
    re_d = rd_ok ? rd_data[2*DW-1:DW] : re_q;
    im_d = rd_ok ? rd_data[DW-1:0] : im_q;
    ovf_d = ovf_q || (in_valid && full_q[wr_bank_q]);
`ifdef FFT_REORDER_IDX_EN
    idx_d = rd_ok ? rd_cnt_q : idx_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
      ovf_q <= 1'b0;
`ifdef FFT_REORDER_IDX_EN
      idx_q <= '0;
`endif
    end else begin
      full_q <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      valid_q <= valid_d;
      last_q <= last_d;
      re_q <= re_d;
      im_q <= im_d;
      ovf_q <= ovf_d;
`ifdef FFT_REORDER_IDX_EN
      idx_q <= idx_d;
`endif
    end
  end
  assign out.valid = valid_q;
  assign out.last = last_q;
  assign out.re = re_q;
  assign out.im = im_q;
  assign overflow = ovf_q;
`ifdef FFT_REORDER_IDX_EN
  assign out.idx = idx_q;
`endif
endmodule
